// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: bus widths, stack page and the stack-controller types.
package arch_defs_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 16;

   localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

   typedef enum logic [1:0] {
      OP_PUSH    = 2'b00,
      OP_PULL    = 2'b01,
      OP_LOAD_SP = 2'b10,
      OP_NOP     = 2'b11
   } stack_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH_REQ,
      ST_PULL_REQ,
      ST_PULL_WAIT,
      ST_DONE
   } stack_state_t;

endpackage

// File: rtl/stack_controller.sv
// Hardware stack controller: services PHA/PLA/PHP/PLP-style push/pull requests
// against a shared single-page stack in RAM through a request/grant arbiter.
module stack_controller
   import arch_defs_pkg::*;
#(
   parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
   parameter logic [7:0] SP_RESET   = 8'hFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [1:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  req_ready,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] pull_data,
   output logic                  done,
   output logic [7:0]            sp,
   output logic                  stack_err
);

   stack_state_t          state, next_state;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  transfer;
   stack_op_t             op;

   assign op       = stack_op_t'(req_op);
   assign transfer = req_valid & req_ready;

   // Address and write data derive only from registered state, so they stay
   // stable for as long as the arbiter withholds the grant.
   assign mem_addr  = {STACK_PAGE, sp};
   assign mem_wdata = data_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         sp        <= SP_RESET;
         data_q    <= '0;
         pull_data <= '0;
         stack_err <= 1'b0;
      end else begin
         state <= next_state;
         if (transfer) begin
            data_q <= req_data;
            if (op == OP_LOAD_SP) begin
               sp        <= req_data[7:0];
               stack_err <= 1'b0;
            end else if (op == OP_PULL) begin
               sp <= sp + 8'd1;
               if (sp == 8'hFF) stack_err <= 1'b1;
            end
         end
         if (state == ST_PUSH_REQ && mem_gnt) begin
            sp <= sp - 8'd1;
            if (sp == 8'h00) stack_err <= 1'b1;
         end
         if (state == ST_PULL_WAIT) pull_data <= mem_rdata;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               case (op)
                  OP_PUSH: next_state = ST_PUSH_REQ;
                  OP_PULL: next_state = ST_PULL_REQ;
                  default: next_state = ST_DONE;
               endcase
            end
         end
         ST_PUSH_REQ: begin
            mem_req = 1'b1;
            mem_we  = mem_gnt;
            if (mem_gnt) next_state = ST_DONE;
         end
         ST_PULL_REQ: begin
            mem_req = 1'b1;
            mem_re  = mem_gnt;
            if (mem_gnt) next_state = ST_PULL_WAIT;
         end
         ST_PULL_WAIT: next_state = ST_DONE;
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_stack_controller.sv
// Directed self-checking bench for stack_controller with a behavioural
// synchronous-read RAM on the arbiter side.
module tb_stack_controller;
   import arch_defs_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  req_valid;
   logic [1:0]            req_op;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  req_ready;
   logic                  mem_req;
   logic                  mem_gnt;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic                  mem_re;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata = '0;
   logic [DATA_WIDTH-1:0] pull_data;
   logic                  done;
   logic [7:0]            sp;
   logic                  stack_err;

   logic [7:0] ram [0:65535];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   stack_controller dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_ready (req_ready),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pull_data (pull_data),
      .done      (done),
      .sp        (sp),
      .stack_err (stack_err)
   );

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issues one operation from a negedge, returns transfer-to-done latency in
   // cycles (99 on timeout) and leaves the DUT back in IDLE at a negedge.
   task automatic run_op(input logic [1:0] op, input logic [7:0] data, output int lat);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 20);
      if (!done) lat = 99;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int  lat;
      logic saw_done;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      req_data  = '0;
      mem_gnt   = 1'b1;
      #12;
      check("rst_sp",        sp,        8'hFF);
      check("rst_err",       stack_err, 1'b0);
      check("rst_done",      done,      1'b0);
      check("rst_ready",     req_ready, 1'b1);
      check("rst_mem_req",   mem_req,   1'b0);
      check("rst_pull_data", pull_data, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // Push 0x88 immediately after reset release.
      run_op(OP_PUSH, 8'h88, lat);
      check("push_lat",  lat,           2);
      check("push_ram",  ram[16'h01FF], 8'h88);
      check("push_sp",   sp,            8'hFE);
      check("push_err",  stack_err,     1'b0);

      run_op(OP_PULL, 8'h00, lat);
      check("pull_lat",  lat,       3);
      check("pull_data", pull_data, 8'h88);
      check("pull_sp",   sp,        8'hFF);
      check("pull_err",  stack_err, 1'b0);

      // Push stalled by the arbiter; a pull offered meanwhile must be ignored.
      mem_gnt   = 1'b0;
      req_valid = 1'b1;
      req_op    = OP_PUSH;
      req_data  = 8'h3C;
      @(posedge clk);
      #1;
      req_op   = OP_PULL;
      req_data = 8'hEE;
      repeat (5) begin
         @(negedge clk);
         check("stall_req",   mem_req,   1'b1);
         check("stall_we",    mem_we,    1'b0);
         check("stall_addr",  mem_addr,  16'h01FF);
         check("stall_wdata", mem_wdata, 8'h3C);
         check("stall_sp",    sp,        8'hFF);
      end
      mem_gnt   = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      @(negedge clk);
      check("stall_done", done,          1'b1);
      check("stall_ram",  ram[16'h01FF], 8'h3C);
      check("stall_sp2",  sp,            8'hFE);
      @(negedge clk);
      check("stall_idle", req_ready, 1'b1);
      check("stall_sp3",  sp,        8'hFE);

      // Overflow: push at sp=0x00 wraps and sets the sticky flag.
      run_op(OP_LOAD_SP, 8'h00, lat);
      check("load_lat", lat, 1);
      check("load_sp",  sp,  8'h00);
      run_op(OP_PUSH, 8'h55, lat);
      check("ovf_ram", ram[16'h0100], 8'h55);
      check("ovf_sp",  sp,            8'hFF);
      check("ovf_err", stack_err,     1'b1);
      run_op(OP_LOAD_SP, 8'h10, lat);
      check("clr_err", stack_err, 1'b0);
      check("clr_sp",  sp,        8'h10);

      // Underflow: pull at sp=0xFF reads 0x0100.
      run_op(OP_LOAD_SP, 8'hFF, lat);
      run_op(OP_PULL, 8'h00, lat);
      check("unf_lat",  lat,       3);
      check("unf_sp",   sp,        8'h00);
      check("unf_err",  stack_err, 1'b1);
      check("unf_data", pull_data, 8'h55);
      run_op(OP_PUSH, 8'hAA, lat);
      check("hold_ram",  ram[16'h0100], 8'hAA);
      check("hold_data", pull_data,     8'h55);
      check("hold_sp",   sp,            8'hFF);

      // Reset in PULL_WAIT.
      req_valid = 1'b1;
      req_op    = OP_PULL;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_ready",  req_ready, 1'b1);
      check("mid_req",    mem_req,   1'b0);
      check("mid_re",     mem_re,    1'b0);
      check("mid_sp",     sp,        8'hFF);
      check("mid_err",    stack_err, 1'b0);
      check("mid_pdata",  pull_data, 8'h00);
      check("mid_done",   done,      1'b0);
      @(negedge clk);
      reset    = 1'b0;
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("mid_no_done", saw_done, 1'b0);

      run_op(OP_LOAD_SP, 8'h42, lat);
      check("post_lat", lat, 1);
      check("post_sp",  sp,  8'h42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
